// File: rtl/flash_ctrl_pkg.sv
// Shared types for the flash controller: operation codes, sequencer states and
// the default command watchdog length.
package flash_ctrl_pkg;

  typedef enum logic [1:0] {
    FlashOpRead    = 2'd0,
    FlashOpProg    = 2'd1,
    FlashOpPgErase = 2'd2,
    FlashOpBkErase = 2'd3
  } flash_op_e;

  typedef enum logic [2:0] {
    SeqIdle      = 3'd0,
    SeqInitWait  = 3'd1,
    SeqProgFetch = 3'd2,
    SeqIssue     = 3'd3,
    SeqRdOut     = 3'd4,
    SeqFinish    = 3'd5
  } seq_state_e;

  localparam int unsigned TimeoutCycDefault = 4096;

  // Program ops need a data word in hand before the first command goes out.
  function automatic seq_state_e first_cmd_state(input flash_op_e op);
    return (op == FlashOpProg) ? SeqProgFetch : SeqIssue;
  endfunction

  function automatic logic is_erase(input flash_op_e op);
    return (op == FlashOpPgErase) || (op == FlashOpBkErase);
  endfunction

endpackage

// File: rtl/flash_op_sequencer.sv
// Splits one software flash operation into single-word flash commands, streaming
// program data in and read data out, with a per-command completion watchdog.
//
// state        | meaning
// SeqIdle      | waiting for op_start_i
// SeqInitWait  | op latched, flash still initialising
// SeqProgFetch | waiting for the next program word
// SeqIssue     | command on the flash port, waiting for its done pulse
// SeqRdOut     | read word presented, waiting for the consumer
// SeqFinish    | one-cycle op_done_o
module flash_op_sequencer
  import flash_ctrl_pkg::*;
#(
  parameter int unsigned AddrW      = 16,
  parameter int unsigned DataWidth  = 32,
  parameter int unsigned CntW       = 12,
  parameter int unsigned TimeoutCyc = TimeoutCycDefault
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 op_start_i,
  input  logic [1:0]           op_type_i,
  input  logic [AddrW-1:0]     op_addr_i,
  input  logic [CntW-1:0]      op_num_words_i,
  output logic                 op_busy_o,
  output logic                 op_done_o,
  output logic                 op_err_o,
  input  logic [DataWidth-1:0] prog_data_i,
  input  logic                 prog_valid_i,
  output logic                 prog_ready_o,
  output logic [DataWidth-1:0] rd_data_o,
  output logic                 rd_valid_o,
  input  logic                 rd_ready_i,
  output logic                 flash_req_o,
  output logic                 flash_rd_o,
  output logic                 flash_prog_o,
  output logic                 flash_pg_erase_o,
  output logic                 flash_bk_erase_o,
  output logic [AddrW-1:0]     flash_addr_o,
  output logic [DataWidth-1:0] flash_prog_data_o,
  input  logic                 flash_rd_done_i,
  input  logic                 flash_prog_done_i,
  input  logic                 flash_erase_done_i,
  input  logic [DataWidth-1:0] flash_rd_data_i,
  input  logic                 flash_init_busy_i
);

  localparam int unsigned TmrW = (TimeoutCyc > 1) ? $clog2(TimeoutCyc) : 1;
  localparam logic [TmrW-1:0] TmrLast = TmrW'(TimeoutCyc - 1);

  seq_state_e           r_state, w_state_n;
  flash_op_e            r_type, w_type_n;
  logic [AddrW-1:0]     r_base, w_base_n;
  logic [CntW-1:0]      r_count, w_count_n;
  logic [CntW-1:0]      r_idx, w_idx_n;
  logic [DataWidth-1:0] r_prog_data, w_prog_data_n;
  logic [DataWidth-1:0] r_rd_data, w_rd_data_n;
  logic [TmrW-1:0]      r_timer;
  logic                 w_timeout;
  logic                 w_cmd_done;

  logic r_busy, r_done, r_err, r_prog_ready, r_rd_valid;
  logic r_req, r_cmd_rd, r_cmd_prog, r_cmd_pg_erase, r_cmd_bk_erase;
  logic [AddrW-1:0] r_addr;

  // Program commands ignore rd_done: the macro reads the word before programming it.
  always_comb begin
    unique case (r_type)
      FlashOpRead: w_cmd_done = flash_rd_done_i;
      FlashOpProg: w_cmd_done = flash_prog_done_i;
      default:     w_cmd_done = flash_erase_done_i;
    endcase
  end

  always_comb begin
    w_state_n     = r_state;
    w_type_n      = r_type;
    w_base_n      = r_base;
    w_count_n     = r_count;
    w_idx_n       = r_idx;
    w_prog_data_n = r_prog_data;
    w_rd_data_n   = r_rd_data;
    w_timeout     = 1'b0;
    unique case (r_state)
      SeqIdle: begin
        if (op_start_i) begin
          w_type_n  = flash_op_e'(op_type_i);
          w_base_n  = op_addr_i;
          w_count_n = op_num_words_i;
          w_idx_n   = '0;
          w_state_n = flash_init_busy_i ? SeqInitWait : first_cmd_state(w_type_n);
        end
      end
      SeqInitWait: begin
        if (!flash_init_busy_i) w_state_n = first_cmd_state(r_type);
      end
      SeqProgFetch: begin
        if (prog_valid_i && r_prog_ready) begin
          w_prog_data_n = prog_data_i;
          w_state_n     = SeqIssue;
        end
      end
      SeqIssue: begin
        if (w_cmd_done) begin
          if (r_type == FlashOpRead) begin
            w_rd_data_n = flash_rd_data_i;
            w_state_n   = SeqRdOut;
          end else if (r_type == FlashOpProg && r_idx != r_count) begin
            w_idx_n   = r_idx + CntW'(1);
            w_state_n = SeqProgFetch;
          end else begin
            w_state_n = SeqFinish;
          end
        end else if (r_timer == TmrLast) begin
          w_timeout = 1'b1;
          w_state_n = SeqIdle;
        end
      end
      SeqRdOut: begin
        if (r_rd_valid && rd_ready_i) begin
          if (r_idx == r_count) begin
            w_state_n = SeqFinish;
          end else begin
            w_idx_n   = r_idx + CntW'(1);
            w_state_n = SeqIssue;
          end
        end
      end
      SeqFinish: w_state_n = SeqIdle;
      default:   w_state_n = SeqIdle;
    endcase
  end

  // Every output is a register loaded from the next state, so it changes only on state edges.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state        <= SeqIdle;
      r_type         <= FlashOpRead;
      r_base         <= '0;
      r_count        <= '0;
      r_idx          <= '0;
      r_prog_data    <= '0;
      r_rd_data      <= '0;
      r_timer        <= '0;
      r_busy         <= 1'b0;
      r_done         <= 1'b0;
      r_err          <= 1'b0;
      r_prog_ready   <= 1'b0;
      r_rd_valid     <= 1'b0;
      r_req          <= 1'b0;
      r_cmd_rd       <= 1'b0;
      r_cmd_prog     <= 1'b0;
      r_cmd_pg_erase <= 1'b0;
      r_cmd_bk_erase <= 1'b0;
      r_addr         <= '0;
    end else begin
      r_state        <= w_state_n;
      r_type         <= w_type_n;
      r_base         <= w_base_n;
      r_count        <= w_count_n;
      r_idx          <= w_idx_n;
      r_prog_data    <= w_prog_data_n;
      r_rd_data      <= w_rd_data_n;
      r_timer        <= (r_state == SeqIssue && w_state_n == SeqIssue) ? r_timer + TmrW'(1) : '0;
      r_busy         <= (w_state_n != SeqIdle);
      r_done         <= (w_state_n == SeqFinish) || w_timeout;
      r_err          <= w_timeout;
      r_prog_ready   <= (w_state_n == SeqProgFetch);
      r_rd_valid     <= (w_state_n == SeqRdOut);
      r_req          <= (w_state_n == SeqIssue);
      r_cmd_rd       <= (w_state_n == SeqIssue) && (w_type_n == FlashOpRead);
      r_cmd_prog     <= (w_state_n == SeqIssue) && (w_type_n == FlashOpProg);
      r_cmd_pg_erase <= (w_state_n == SeqIssue) && (w_type_n == FlashOpPgErase);
      r_cmd_bk_erase <= (w_state_n == SeqIssue) && (w_type_n == FlashOpBkErase);
      r_addr         <= is_erase(w_type_n) ? w_base_n : w_base_n + AddrW'(w_idx_n);
    end
  end

  assign op_busy_o         = r_busy;
  assign op_done_o         = r_done;
  assign op_err_o          = r_err;
  assign prog_ready_o      = r_prog_ready;
  assign rd_data_o         = r_rd_data;
  assign rd_valid_o        = r_rd_valid;
  assign flash_req_o       = r_req;
  assign flash_rd_o        = r_cmd_rd;
  assign flash_prog_o      = r_cmd_prog;
  assign flash_pg_erase_o  = r_cmd_pg_erase;
  assign flash_bk_erase_o  = r_cmd_bk_erase;
  assign flash_addr_o      = r_addr;
  assign flash_prog_data_o = r_prog_data;

endmodule

// File: tb/tb_flash_op_sequencer.sv
// Bench for flash_op_sequencer: a behavioural flash macro checks each command
// against a queue of expected commands, and a read monitor checks returned words.
module tb_flash_op_sequencer;

  logic        clk_i = 1'b0;
  logic        rst_i = 1'b0;
  logic        op_start_i = 1'b0;
  logic [1:0]  op_type_i = 2'd0;
  logic [15:0] op_addr_i = '0;
  logic [11:0] op_num_words_i = '0;
  logic        op_busy_o, op_done_o, op_err_o;
  logic [31:0] prog_data_i = '0;
  logic        prog_valid_i = 1'b0;
  logic        prog_ready_o;
  logic [31:0] rd_data_o;
  logic        rd_valid_o;
  logic        rd_ready_i = 1'b0;
  logic        flash_req_o, flash_rd_o, flash_prog_o, flash_pg_erase_o, flash_bk_erase_o;
  logic [15:0] flash_addr_o;
  logic [31:0] flash_prog_data_o;
  logic        flash_rd_done_i = 1'b0;
  logic        flash_prog_done_i = 1'b0;
  logic        flash_erase_done_i = 1'b0;
  logic [31:0] flash_rd_data_i = '0;
  logic        flash_init_busy_i = 1'b0;

  flash_op_sequencer dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .op_start_i(op_start_i), .op_type_i(op_type_i), .op_addr_i(op_addr_i),
    .op_num_words_i(op_num_words_i), .op_busy_o(op_busy_o), .op_done_o(op_done_o),
    .op_err_o(op_err_o), .prog_data_i(prog_data_i), .prog_valid_i(prog_valid_i),
    .prog_ready_o(prog_ready_o), .rd_data_o(rd_data_o), .rd_valid_o(rd_valid_o),
    .rd_ready_i(rd_ready_i), .flash_req_o(flash_req_o), .flash_rd_o(flash_rd_o),
    .flash_prog_o(flash_prog_o), .flash_pg_erase_o(flash_pg_erase_o),
    .flash_bk_erase_o(flash_bk_erase_o), .flash_addr_o(flash_addr_o),
    .flash_prog_data_o(flash_prog_data_o), .flash_rd_done_i(flash_rd_done_i),
    .flash_prog_done_i(flash_prog_done_i), .flash_erase_done_i(flash_erase_done_i),
    .flash_rd_data_i(flash_rd_data_i), .flash_init_busy_i(flash_init_busy_i)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    logic [15:0] addr;
    logic [1:0]  typ;
    logic [31:0] data;
  } cmd_t;

  cmd_t        q_cmd[$];
  logic [31:0] q_rd[$];

  int checks = 0;
  int failures = 0;
  int n_cmds = 0;
  int n_prog_done = 0;
  int rd_beats = 0;

  int          f_lat = 3;
  bit          f_hang = 0;
  bit          f_late = 0;
  bit          f_active = 0;
  bit          f_pulsed = 0;
  int          f_cnt = 0;
  logic [15:0] f_addr = '0;
  logic [1:0]  f_typ = '0;

  function automatic logic [31:0] f_data(input logic [15:0] a);
    return {a ^ 16'hA55A, ~a};
  endfunction

  // Flash macro model: takes a command on the first req-high cycle, answers after f_lat cycles.
  always begin
    cmd_t       c;
    logic [3:0] one;
    logic [3:0] got;
    @(posedge clk_i);
    #1;
    flash_rd_done_i    = 1'b0;
    flash_prog_done_i  = 1'b0;
    flash_erase_done_i = 1'b0;
    flash_rd_data_i    = 32'hDEAD_BEEF;
    if (f_late) begin
      flash_erase_done_i = 1'b1;
      f_late = 0;
    end
    got = {flash_bk_erase_o, flash_pg_erase_o, flash_prog_o, flash_rd_o};
    if (rst_i || !flash_req_o) begin
      f_active = 0;
    end else if (!f_active) begin
      f_active = 1;
      f_pulsed = 0;
      f_cnt    = f_lat;
      f_addr   = flash_addr_o;
      f_typ    = flash_prog_o ? 2'd1 : flash_pg_erase_o ? 2'd2 : flash_bk_erase_o ? 2'd3 : 2'd0;
      n_cmds++;
      checks++;
      if (q_cmd.size() == 0) begin
        failures++;
        $display("FAIL cmd_unexpected addr=%h type=%b", flash_addr_o, got);
      end else begin
        c = q_cmd.pop_front();
        one = 4'b0001;
        one = one << c.typ;
        if (flash_addr_o !== c.addr || got !== one ||
            (c.typ == 2'd1 && flash_prog_data_o !== c.data)) begin
          failures++;
          $display("FAIL cmd addr=%h type=%b data=%h expected addr=%h type=%b data=%h",
                   flash_addr_o, got, flash_prog_data_o, c.addr, one, c.data);
        end
      end
    end else begin
      checks++;
      if (flash_addr_o !== f_addr) begin
        failures++;
        $display("FAIL cmd_stable addr=%h expected %h", flash_addr_o, f_addr);
      end
      if (!f_pulsed && !f_hang) begin
        if (f_typ == 2'd1 && f_cnt == 2) flash_rd_done_i = 1'b1;
        if (f_cnt == 0) begin
          case (f_typ)
            2'd0: begin
              flash_rd_done_i = 1'b1;
              flash_rd_data_i = f_data(f_addr);
            end
            2'd1: begin
              flash_prog_done_i = 1'b1;
              n_prog_done++;
            end
            default: flash_erase_done_i = 1'b1;
          endcase
          f_pulsed = 1;
        end else begin
          f_cnt--;
        end
      end
    end
  end

  // Read consumer: a handshake completes at the posedge following this sample.
  always @(negedge clk_i) begin
    logic [31:0] e;
    if (!rst_i && rd_valid_o && rd_ready_i) begin
      rd_beats++;
      checks++;
      if (q_rd.size() == 0) begin
        failures++;
        $display("FAIL rd_unexpected data=%h", rd_data_o);
      end else begin
        e = q_rd.pop_front();
        if (rd_data_o !== e) begin
          failures++;
          $display("FAIL rd_data got=%h expected=%h", rd_data_o, e);
        end
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL global_timeout checks=%0d failures=%0d", checks, failures);
    $fatal(1, "bench time limit");
  end

  task automatic start_op(input logic [1:0] t, input logic [15:0] a, input logic [11:0] n);
    op_type_i      = t;
    op_addr_i      = a;
    op_num_words_i = n;
    op_start_i     = 1'b1;
    @(posedge clk_i);
    #1;
    op_start_i = 1'b0;
  endtask

  task automatic wait_done(input int budget, output bit got, output bit err);
    got = 0;
    err = 0;
    for (int i = 0; i < budget && !got; i++) begin
      @(negedge clk_i);
      if (op_done_o) begin
        got = 1;
        err = op_err_o;
      end
    end
    @(posedge clk_i);
    #1;
  endtask

  task automatic push_read(input logic [15:0] a, input int words);
    logic [15:0] ai;
    for (int i = 0; i < words; i++) begin
      ai = a + 16'(i);
      q_cmd.push_back('{addr: ai, typ: 2'd0, data: '0});
      q_rd.push_back(f_data(ai));
    end
  endtask

  task automatic send_word(input logic [31:0] d, output bit acc);
    acc = 0;
    prog_data_i  = d;
    prog_valid_i = 1'b1;
    for (int i = 0; i < 60 && !acc; i++) begin
      @(negedge clk_i);
      if (prog_ready_o) acc = 1;
      @(posedge clk_i);
      #1;
    end
    prog_valid_i = 1'b0;
  endtask

  task automatic test_reset;
    rst_i = 1'b1;
    #12;
    checks++;
    if ({op_busy_o, op_done_o, op_err_o, prog_ready_o, rd_valid_o, flash_req_o,
         flash_rd_o, flash_prog_o, flash_pg_erase_o, flash_bk_erase_o} !== 10'b0 ||
        flash_addr_o !== 16'h0 || flash_prog_data_o !== 32'h0 || rd_data_o !== 32'h0) begin
      failures++;
      $display("FAIL reset_outputs busy=%b done=%b req=%b addr=%h rd_data=%h expected all zero",
               op_busy_o, op_done_o, flash_req_o, flash_addr_o, rd_data_o);
    end
    @(posedge clk_i);
    #1;
    rst_i = 1'b0;
    @(posedge clk_i);
    #1;
  endtask

  task automatic test_read;
    bit got, err;
    int c0, b0;
    c0 = n_cmds;
    b0 = rd_beats;
    push_read(16'h0010, 3);
    rd_ready_i = 1'b1;
    start_op(2'd0, 16'h0010, 12'd2);
    wait_done(200, got, err);
    checks++;
    if (!got || err) begin
      failures++;
      $display("FAIL read_done got=%b err=%b expected done=1 err=0", got, err);
    end
    checks++;
    if (n_cmds - c0 != 3 || rd_beats - b0 != 3) begin
      failures++;
      $display("FAIL read_counts cmds=%0d beats=%0d expected 3 and 3", n_cmds - c0, rd_beats - b0);
    end
  endtask

  task automatic test_prog;
    bit got, err, acc0, acc1, ok;
    int p0;
    p0 = n_prog_done;
    q_cmd.push_back('{addr: 16'h0100, typ: 2'd1, data: 32'hA5A5_A5A5});
    q_cmd.push_back('{addr: 16'h0101, typ: 2'd1, data: 32'h0F0F_0F0F});
    start_op(2'd1, 16'h0100, 12'd1);
    ok = 1;
    repeat (5) begin
      if (flash_req_o !== 1'b0 || prog_ready_o !== 1'b1) ok = 0;
      @(posedge clk_i);
      #1;
    end
    checks++;
    if (!ok) begin
      failures++;
      $display("FAIL prog_wait_for_data req=%b ready=%b expected req=0 ready=1", flash_req_o, prog_ready_o);
    end
    send_word(32'hA5A5_A5A5, acc0);
    send_word(32'h0F0F_0F0F, acc1);
    checks++;
    if (!acc0 || !acc1) begin
      failures++;
      $display("FAIL prog_accept word0=%b word1=%b expected 1 and 1", acc0, acc1);
    end
    wait_done(200, got, err);
    checks++;
    if (!got || err || n_prog_done - p0 != 2) begin
      failures++;
      $display("FAIL prog_done got=%b err=%b prog_done_pulses=%0d expected 1 0 2", got, err, n_prog_done - p0);
    end
  endtask

  task automatic test_pg_erase;
    bit seen, req_at, pg_at, done_next, req_next;
    int c0;
    c0 = n_cmds;
    seen = 0;
    req_at = 0;
    pg_at = 0;
    q_cmd.push_back('{addr: 16'h0200, typ: 2'd2, data: '0});
    start_op(2'd2, 16'h0200, 12'd0);
    for (int i = 0; i < 50 && !seen; i++) begin
      @(negedge clk_i);
      if (flash_erase_done_i) begin
        seen   = 1;
        req_at = flash_req_o;
        pg_at  = flash_pg_erase_o;
      end
    end
    @(negedge clk_i);
    done_next = op_done_o;
    req_next  = flash_req_o;
    checks++;
    if (!seen || !req_at || !pg_at) begin
      failures++;
      $display("FAIL erase_held seen=%b req=%b pg_erase=%b expected 1 1 1", seen, req_at, pg_at);
    end
    checks++;
    if (!done_next || req_next) begin
      failures++;
      $display("FAIL erase_finish done=%b req=%b expected done=1 req=0", done_next, req_next);
    end
    @(posedge clk_i);
    #1;
    checks++;
    if (n_cmds - c0 != 1) begin
      failures++;
      $display("FAIL erase_cmd_count got=%0d expected 1", n_cmds - c0);
    end
  endtask

  task automatic test_init_wait;
    bit got, err, ok;
    flash_init_busy_i = 1'b1;
    push_read(16'h0040, 1);
    start_op(2'd0, 16'h0040, 12'd0);
    ok = 1;
    repeat (20) begin
      @(negedge clk_i);
      if (flash_req_o || !op_busy_o) ok = 0;
    end
    checks++;
    if (!ok) begin
      failures++;
      $display("FAIL init_hold req=%b busy=%b expected req=0 busy=1", flash_req_o, op_busy_o);
    end
    @(posedge clk_i);
    #1;
    flash_init_busy_i = 1'b0;
    wait_done(200, got, err);
    checks++;
    if (!got || err) begin
      failures++;
      $display("FAIL init_op_done got=%b err=%b expected 1 0", got, err);
    end
  endtask

  task automatic test_timeout;
    int cnt;
    bit d, e, ok;
    f_hang = 1;
    q_cmd.push_back('{addr: 16'h1234, typ: 2'd3, data: '0});
    start_op(2'd3, 16'h1234, 12'd0);
    @(negedge clk_i);
    for (int i = 0; i < 10 && !flash_req_o; i++) @(negedge clk_i);
    cnt = 0;
    while (flash_req_o && cnt < 5000) begin
      cnt++;
      @(negedge clk_i);
    end
    d = op_done_o;
    e = op_err_o;
    checks++;
    if (cnt != 4096) begin
      failures++;
      $display("FAIL timeout_len req_cycles=%0d expected 4096", cnt);
    end
    checks++;
    if (!d || !e) begin
      failures++;
      $display("FAIL timeout_pulse done=%b err=%b expected 1 1", d, e);
    end
    @(posedge clk_i);
    #1;
    f_late = 1;
    ok = 1;
    repeat (6) begin
      @(negedge clk_i);
      if (op_done_o || op_err_o || op_busy_o || flash_req_o) ok = 0;
    end
    checks++;
    if (!ok) begin
      failures++;
      $display("FAIL late_done_ignored done=%b busy=%b req=%b expected all 0", op_done_o, op_busy_o, flash_req_o);
    end
    f_hang = 0;
    @(posedge clk_i);
    #1;
  endtask

  task automatic test_wrap;
    bit got, err, seen, stable;
    logic [31:0] held;
    rd_ready_i = 1'b0;
    push_read(16'hFFFF, 2);
    start_op(2'd0, 16'hFFFF, 12'd1);
    seen = 0;
    for (int i = 0; i < 100 && !seen; i++) begin
      @(negedge clk_i);
      if (rd_valid_o) seen = 1;
    end
    held = rd_data_o;
    checks++;
    if (!seen || held !== f_data(16'hFFFF)) begin
      failures++;
      $display("FAIL wrap_first_word valid=%b data=%h expected valid=1 data=%h", seen, held, f_data(16'hFFFF));
    end
    stable = 1;
    repeat (10) begin
      @(negedge clk_i);
      if (!rd_valid_o || rd_data_o !== held) stable = 0;
    end
    checks++;
    if (!stable) begin
      failures++;
      $display("FAIL rd_stall_stable valid=%b data=%h expected valid=1 data=%h", rd_valid_o, rd_data_o, held);
    end
    @(posedge clk_i);
    #1;
    rd_ready_i = 1'b1;
    wait_done(200, got, err);
    checks++;
    if (!got || err || q_cmd.size() != 0 || q_rd.size() != 0) begin
      failures++;
      $display("FAIL wrap_done got=%b err=%b cmds_left=%0d rd_left=%0d expected 1 0 0 0",
               got, err, q_cmd.size(), q_rd.size());
    end
  endtask

  task automatic test_reset_midop;
    bit req_before, ok;
    f_lat = 30;
    rd_ready_i = 1'b1;
    push_read(16'h0500, 4);
    start_op(2'd0, 16'h0500, 12'd3);
    for (int i = 0; i < 10 && !flash_req_o; i++) @(negedge clk_i);
    repeat (3) @(negedge clk_i);
    req_before = flash_req_o;
    #1;
    rst_i = 1'b1;
    #1;
    checks++;
    if (!req_before || flash_req_o !== 1'b0 || op_busy_o !== 1'b0) begin
      failures++;
      $display("FAIL reset_midop req_before=%b req=%b busy=%b expected 1 0 0", req_before, flash_req_o, op_busy_o);
    end
    @(posedge clk_i);
    #1;
    @(posedge clk_i);
    #1;
    rst_i = 1'b0;
    q_cmd.delete();
    q_rd.delete();
    f_lat = 3;
    ok = 1;
    repeat (3) begin
      @(negedge clk_i);
      if (flash_req_o || op_busy_o || rd_valid_o) ok = 0;
    end
    checks++;
    if (!ok) begin
      failures++;
      $display("FAIL reset_idle req=%b busy=%b rd_valid=%b expected 0 0 0", flash_req_o, op_busy_o, rd_valid_o);
    end
    @(posedge clk_i);
    #1;
  endtask

  task automatic test_back_to_back;
    bit got, err, fin;
    int c0;
    c0 = n_cmds;
    q_cmd.push_back('{addr: 16'h0200, typ: 2'd2, data: '0});
    start_op(2'd2, 16'h0200, 12'd0);
    fin = 0;
    for (int i = 0; i < 50 && !fin; i++) begin
      if (op_done_o) fin = 1;
      else begin
        @(posedge clk_i);
        #1;
      end
    end
    op_type_i      = 2'd0;
    op_addr_i      = 16'h0777;
    op_num_words_i = 12'd0;
    op_start_i     = 1'b1;
    @(posedge clk_i);
    #1;
    op_start_i = 1'b0;
    checks++;
    if (!fin || op_busy_o !== 1'b0) begin
      failures++;
      $display("FAIL start_in_finish finish_seen=%b busy=%b expected 1 0", fin, op_busy_o);
    end
    q_cmd.push_back('{addr: 16'h3000, typ: 2'd3, data: '0});
    start_op(2'd3, 16'h3000, 12'd0);
    checks++;
    if (op_busy_o !== 1'b1) begin
      failures++;
      $display("FAIL start_after_finish busy=%b expected 1", op_busy_o);
    end
    wait_done(200, got, err);
    checks++;
    if (!got || err || n_cmds - c0 != 2 || q_cmd.size() != 0) begin
      failures++;
      $display("FAIL back_to_back got=%b err=%b cmds=%0d left=%0d expected 1 0 2 0",
               got, err, n_cmds - c0, q_cmd.size());
    end
  endtask

  initial begin
    test_reset();
    test_read();
    test_prog();
    test_pg_erase();
    test_init_wait();
    test_timeout();
    test_wrap();
    test_reset_midop();
    test_back_to_back();
    checks++;
    if (q_cmd.size() != 0 || q_rd.size() != 0) begin
      failures++;
      $display("FAIL scoreboard_drain cmds_left=%0d rd_left=%0d expected 0 0", q_cmd.size(), q_rd.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
